// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared FSM state codes, error-bit indices and row width for the frame sequencer
package jpeg_pkg;
  localparam int ROW_W = 64;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam int ERR_SYNC = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_TO = 2;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: byte valid/ready to MSB-first serial bits, gapless, stops accepting after the last byte
module bit_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  output logic       ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       done
);
  logic [7:0] sh;
  logic [2:0] left;
  logic       full;
  logic       last_seen;
  logic       final_bit;
  // a new byte can load on the same edge the previous byte's bit 0 leaves
  assign final_bit = full && left == 3'd0;
  assign ready = en && (!full || final_bit) && !last_seen;
  assign bit_out = sh[7];
  assign bit_valid = full;
  assign done = final_bit && last_seen;
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      left <= '0;
      full <= 1'b0;
      last_seen <= 1'b0;
    end else if (ready && valid) begin
      sh <= data;
      left <= 3'd7;
      full <= 1'b1;
      last_seen <= last;
    end else if (full) begin
      sh <= {sh[6:0], 1'b0};
      left <= left - 3'd1;
      full <= !final_bit;
    end
endmodule

// File: rtl/jpeg_frame_sequencer.sv
// jpeg_frame_sequencer: feeds one compressed frame into the decoder pipeline and writes its
// pixel rows to the frame buffer in raster order, flagging sync, overflow and timeout errors
module jpeg_frame_sequencer
  import jpeg_pkg::*;
#(
  parameter int BLOCKS_W = 40,
  parameter int BLOCKS_H = 30,
  parameter int ADDR_W = 14,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid_in,
  input  logic              byte_last_in,
  output logic              byte_ready_out,
  output logic              serial_out,
  output logic              serial_valid_out,
  output logic              dec_rst_out,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              row_valid_in,
  input  logic              row_final_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [ROW_W-1:0]  wr_data_out,
  output logic              wr_en_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [2:0]        err_out
);
  localparam int NBLK = BLOCKS_W * BLOCKS_H;
  localparam int BX_W = $clog2(BLOCKS_W + 1);
  localparam int BY_W = $clog2(BLOCKS_H + 1);
  localparam int NB_W = $clog2(NBLK + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [2:0]        state;
  logic [2:0]        next;
  logic [BX_W-1:0]   bx;
  logic [BY_W-1:0]   by;
  logic [2:0]        r;
  logic [NB_W-1:0]   blocks;
  logic [TO_W-1:0]   idle;
  logic [ADDR_W-1:0] addr;
  logic              last_bit;
  logic              all_done;
  logic              timeout;
  logic              row_ok;
  logic              last_col;
  bit_serializer u_ser (
    .clk(clk_in),
    .rst(!rst_in || state == CLEAR),
    .en(state == FEED),
    .data(byte_in),
    .valid(byte_valid_in),
    .last(byte_last_in),
    .ready(byte_ready_out),
    .bit_out(serial_out),
    .bit_valid(serial_valid_out),
    .done(last_bit)
  );
  assign all_done = blocks == NB_W'(NBLK);
  // the idle count reaches TIMEOUT on the same edge that leaves DRAIN
  assign timeout = idle == TO_W'(TIMEOUT - 1) && !row_valid_in;
  assign row_ok = row_valid_in && (state == FEED || state == DRAIN);
  assign last_col = bx == BX_W'(BLOCKS_W - 1);
  assign addr = (ADDR_W'(by) * ADDR_W'(8) + ADDR_W'(r)) * ADDR_W'(BLOCKS_W) + ADDR_W'(bx);
  assign busy_out = state == CLEAR || state == FEED || state == DRAIN;
  assign done_out = state == DONE;
  assign dec_rst_out = !(state == FEED || state == DRAIN);
  assign next = (state == IDLE || state == DONE) ? (start_in ? CLEAR : state) :
                state == CLEAR ? FEED :
                state == FEED ? (last_bit ? DRAIN : FEED) :
                state == DRAIN ? ((all_done || timeout) ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      state <= IDLE;
      bx <= '0;
      by <= '0;
      r <= '0;
      blocks <= '0;
      idle <= '0;
      err_out <= '0;
      wr_en_out <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      state <= next;
      wr_en_out <= 1'b0;
      idle <= (state == DRAIN && !row_valid_in) ? idle + 1'b1 : '0;
      if (state == CLEAR) begin
        bx <= '0;
        by <= '0;
        r <= '0;
        blocks <= '0;
        err_out <= '0;
      end else if (row_ok && all_done) begin
        err_out[ERR_OVF] <= 1'b1;
      end else if (row_ok) begin
        wr_en_out <= 1'b1;
        wr_data_out <= row_in;
        wr_addr_out <= addr;
        r <= (row_final_in || r == 3'd7) ? 3'd0 : r + 3'd1;
        // a block boundary must coincide with row 7; either mismatch is a sync error
        if (row_final_in != (r == 3'd7)) err_out[ERR_SYNC] <= 1'b1;
        if (row_final_in) begin
          blocks <= blocks + 1'b1;
          bx <= last_col ? '0 : bx + 1'b1;
          if (last_col) by <= by + 1'b1;
        end
      end
      if (state == DRAIN && timeout && !all_done) err_out[ERR_TO] <= 1'b1;
    end
endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
// tb_jpeg_frame_sequencer: randomized scenario bench with a block-index address model
module tb_jpeg_frame_sequencer;
  localparam int W = 3;
  localparam int H = 2;
  localparam int NBLK = W * H;
  logic clk = 0, rst = 0, start = 0, byte_valid = 0, byte_last = 0, row_valid = 0, row_final = 0;
  logic [7:0] byte_d = 0;
  logic [63:0] row = 0;
  logic byte_ready, ser, ser_valid, dec_rst, wr_en, busy, done;
  logic [13:0] wr_addr;
  logic [63:0] wr_data;
  logic [2:0] err;
  int total = 0, passed = 0, blk = 0, r = 0;
  logic [2:0] exp_err = 0;
  logic [7:0] bq[$];
  always #5 clk = ~clk;
  jpeg_frame_sequencer #(.BLOCKS_W(W), .BLOCKS_H(H), .ADDR_W(14), .TIMEOUT(16)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .byte_in(byte_d), .byte_valid_in(byte_valid), .byte_last_in(byte_last), .byte_ready_out(byte_ready),
    .serial_out(ser), .serial_valid_out(ser_valid), .dec_rst_out(dec_rst),
    .row_in(row), .row_valid_in(row_valid), .row_final_in(row_final),
    .wr_addr_out(wr_addr), .wr_data_out(wr_data), .wr_en_out(wr_en),
    .busy_out(busy), .done_out(done), .err_out(err)
  );
  task automatic do_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    total++; if ({busy, dec_rst} !== 2'b11) $display("FAIL clear_state: busy,dec_rst=%b want 11", {busy, dec_rst}); else passed++;
    @(negedge clk);
    total++;
    if ({busy, dec_rst, ser_valid, byte_ready, err} !== 7'b1001000)
      $display("FAIL feed_entry: busy,dec_rst,ser_valid,ready,err=%b want 1001000", {busy, dec_rst, ser_valid, byte_ready, err});
    else passed++;
    blk = 0; r = 0; exp_err = 0;
  endtask
  task automatic feed_bytes(input bit gaps);
    logic exp_bits[$];
    int idx = 0, cyc = 0, first = -1, lastc = -1, nbits = 0, n;
    n = bq.size();
    foreach (bq[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(bq[i][b]);
    while (nbits < 8 * n && cyc < 1000) begin
      if (idx == n) begin
        total++; if (byte_ready !== 1'b0) $display("FAIL ready_after_last: got %b want 0", byte_ready); else passed++;
      end
      byte_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
      byte_d = (idx < n) ? bq[idx] : 8'h00;
      byte_last = idx == n - 1;
      start = gaps && $urandom_range(0, 7) == 0;
      if (byte_valid && byte_ready) idx++;
      @(negedge clk); cyc++;
      if (ser_valid) begin
        total++;
        if (ser !== exp_bits[nbits]) $display("FAIL ser_bit%0d: got %b want %b", nbits, ser, exp_bits[nbits]); else passed++;
        if (first < 0) first = cyc;
        lastc = cyc; nbits++;
      end
    end
    byte_valid = 0; byte_last = 0; start = 0;
    total++; if (nbits != 8 * n) $display("FAIL ser_count: got %0d bits want %0d", nbits, 8 * n); else passed++;
    if (!gaps) begin
      total++; if (lastc - first + 1 != 8 * n) $display("FAIL ser_gapless: span %0d want %0d", lastc - first + 1, 8 * n); else passed++;
    end
    @(negedge clk);
    total++;
    if ({ser_valid, byte_ready, busy, dec_rst} !== 4'b0010)
      $display("FAIL drain_entry: ser_valid,ready,busy,dec_rst=%b want 0010", {ser_valid, byte_ready, busy, dec_rst});
    else passed++;
  endtask
  task automatic run_rows(input bit clean, input int extra);
    int guard = 0, gap = 0, naddr = 0;
    bit npend;
    logic [63:0] ndata = '0;
    while ((blk < NBLK || extra > 0) && guard < 2000) begin
      guard++; npend = 0;
      row_valid = gap >= 4 || $urandom_range(0, 3) != 0;
      row = {$urandom, $urandom}; row_final = 0;
      if (row_valid) begin
        gap = 0;
        if (blk == NBLK) begin
          extra--; row_final = 1'($urandom_range(0, 1)); exp_err[1] = 1;
        end else begin
          if (clean) row_final = r == 7;
          else if (blk == 0 && r == 4) row_final = 1;
          else row_final = (r == 7) ? $urandom_range(0, 9) != 0 : $urandom_range(0, 19) == 0;
          npend = 1; ndata = row;
          naddr = ((blk / W) * 8 + r) * W + blk % W;
          if (row_final != (r == 7)) exp_err[0] = 1;
          if (row_final) begin r = 0; blk++; end
          else r = (r == 7) ? 0 : r + 1;
        end
      end else gap++;
      @(negedge clk);
      total++; if (wr_en !== npend) $display("FAIL wr_en: got %b want %b", wr_en, npend); else passed++;
      if (npend) begin
        total++;
        if ({wr_addr, wr_data} !== {14'(naddr), ndata})
          $display("FAIL wr_addr_data: got %0d/%h want %0d/%h", wr_addr, wr_data, naddr, ndata);
        else passed++;
      end
    end
    row_valid = 0; row_final = 0;
  endtask
  task automatic check_done(input string name);
    @(negedge clk);
    total++;
    if ({done, busy, dec_rst, err} !== {3'b101, exp_err})
      $display("FAIL %s: done,busy,dec_rst,err=%b want %b", name, {done, busy, dec_rst, err}, {3'b101, exp_err});
    else passed++;
  endtask
  task automatic test_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({byte_ready, ser, ser_valid, dec_rst, wr_en, busy, done, err, wr_addr, wr_data} !== {7'b0001000, 3'b0, 14'b0, 64'b0})
      $display("FAIL reset_outputs: ready,ser,sv,dec_rst,wr_en,busy,done=%b err=%b addr=%0d data=%h",
               {byte_ready, ser, ser_valid, dec_rst, wr_en, busy, done}, err, wr_addr, wr_data);
    else passed++;
    rst = 1;
  endtask
  task automatic test_serial_timeout();
    int cyc = 1;
    do_start();
    bq = '{8'hA5, 8'h3C};
    feed_bytes(0);
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    total++; if (cyc != 17) $display("FAIL timeout_cycles: done seen after %0d want 17", cyc); else passed++;
    exp_err = 3'b100;
    total++;
    if ({done, busy, dec_rst, err} !== 6'b101100) $display("FAIL timeout_state: done,busy,dec_rst,err=%b want 101100", {done, busy, dec_rst, err});
    else passed++;
  endtask
  task automatic test_frame_clean();
    do_start();
    run_rows(1, 0);
    bq = '{8'($urandom)};
    feed_bytes(0);
    check_done("clean_done");
  endtask
  task automatic test_back_to_back_overflow();
    do_start();
    run_rows(0, 3);
    bq.delete();
    repeat ($urandom_range(1, 3)) bq.push_back(8'($urandom));
    feed_bytes(1);
    check_done("overflow_done");
    row_valid = 1; row_final = 1; row = {$urandom, $urandom};
    @(negedge clk);
    row_valid = 0; row_final = 0;
    total++; if ({wr_en, err} !== {1'b0, exp_err}) $display("FAIL drop_in_done: wr_en,err=%b want %b", {wr_en, err}, {1'b0, exp_err}); else passed++;
  endtask
  task automatic test_drain_rows();
    do_start();
    bq.delete();
    repeat ($urandom_range(2, 5)) bq.push_back(8'($urandom));
    feed_bytes(1);
    run_rows(0, 0);
    check_done("drain_done");
  endtask
  task automatic test_reset_mid_feed();
    do_start();
    byte_valid = 1; byte_last = 0;
    repeat (4) begin byte_d = 8'($urandom); @(negedge clk); end
    start = 1;
    @(negedge clk);
    start = 0;
    total++;
    if ({ser_valid, busy, dec_rst} !== 3'b110) $display("FAIL start_in_feed: sv,busy,dec_rst=%b want 110", {ser_valid, busy, dec_rst});
    else passed++;
    rst = 0; row_valid = 1; row = {$urandom, $urandom};
    @(negedge clk);
    total++;
    if ({ser_valid, byte_ready, dec_rst, busy, wr_en, done, err} !== 9'b001000000)
      $display("FAIL reset_mid_feed: sv,ready,dec_rst,busy,wr_en,done,err=%b want 001000000", {ser_valid, byte_ready, dec_rst, busy, wr_en, done, err});
    else passed++;
    rst = 1; row_valid = 0; byte_valid = 0;
    @(negedge clk);
    total++; if ({busy, dec_rst, ser_valid} !== 3'b010) $display("FAIL idle_after_reset: busy,dec_rst,sv=%b want 010", {busy, dec_rst, ser_valid}); else passed++;
  endtask
  initial begin
    test_reset();
    test_serial_timeout();
    test_frame_clean();
    test_back_to_back_overflow();
    test_drain_rows();
    test_frame_clean();
    test_reset_mid_feed();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/jpeg_frame_sequencer.md
Name: jpeg_frame_sequencer

Overview:
Sequences one JPEG frame through the decoder pipeline (huffman → entropy → zigzag → dequant → 2-D IDCT). It accepts the compressed stream as bytes over a valid/ready handshake and serialises it MSB-first onto the decoder's serial input. It collects the 64-bit pixel rows the pipeline produces and turns them into frame-buffer writes with raster addresses. It counts blocks to detect frame completion, and flags sync, overflow and timeout errors.

Parameters:
BLOCKS_W, 40, 8x8 blocks per image row
BLOCKS_H, 30, block rows per image
ADDR_W, 14, frame-buffer word-address width; must satisfy 2^ADDR_W >= BLOCKS_W*BLOCKS_H*8
TIMEOUT, 4096, DRAIN cycles allowed without any row_valid_in before timeout

Ports:
clk_in  in  1  clock
rst_in  in  1  reset: synchronous, active-low
start_in  in  1  frame start pulse; honoured only in IDLE or DONE
byte_in  in  8  compressed stream byte
byte_valid_in  in  1  byte valid
byte_last_in  in  1  final byte of frame, qualified by byte_valid_in
byte_ready_out  out  1  sequencer accepts byte this cycle
serial_out  out  1  bit to decoder serial_in
serial_valid_out  out  1  to decoder valid_in
dec_rst_out  out  1  active-high reset to decoder pipeline
row_in  in  64  pixel row from decoder (pixel 0 in [7:0])
row_valid_in  in  1  row valid
row_final_in  in  1  last row of a block
wr_addr_out  out  ADDR_W  frame-buffer word address
wr_data_out  out  64  frame-buffer data
wr_en_out  out  1  write strobe
busy_out  out  1  state is CLEAR, FEED or DRAIN
done_out  out  1  high in DONE
err_out  out  3  sticky errors: [0] sync, [1] overflow, [2] timeout

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - state=IDLE; all counters cleared; err_out=0.
  - Every output is 0 except dec_rst_out=1.
  - Reset mid-frame abandons the frame immediately. No write or serial bit is issued on the cycle after reset.
- FSM:
  - IDLE: dec_rst_out=1. start_in → CLEAR.
  - CLEAR: exactly 1 cycle. dec_rst_out=1; clears block, row and bit counters and err_out → FEED.
  - FEED: dec_rst_out=0. Serialises bytes. After bit 0 of the byte_last_in byte has been emitted → DRAIN.
  - DRAIN: leaves when the completed-block count reaches BLOCKS_W*BLOCKS_H, or when the idle counter reaches TIMEOUT (sets err[2]) → DONE.
  - DONE: done_out=1, dec_rst_out=1. start_in → CLEAR.
  - start_in in CLEAR, FEED or DRAIN is ignored.
- Serialiser:
  - One 8-bit shift register plus a 3-bit bits-left count.
  - byte_ready_out = FEED && (empty || emitting the last bit this cycle) && !last_seen. This gives gapless streaming.
  - A byte accepted at edge t has bit 7 on serial_out, with serial_valid_out=1, from t+1. Bits 6..0 follow on consecutive cycles.
  - If no byte is available, serial_valid_out=0 (bubble). The decoder tolerates bubbles.
  - Once the last byte is accepted, byte_ready_out stays 0 for the rest of the frame.
- Row writer:
  - Active in FEED and DRAIN. Rows arriving in other states are dropped.
  - Each row_valid_in produces a registered write one cycle later: wr_en_out=1, wr_data_out=row_in.
  - wr_addr_out = (by*8 + r)*BLOCKS_W + bx, where bx, by are block coordinates and r is the row 0..7 within the block.
  - r increments per row. row_final_in advances bx (wrap to 0 at BLOCKS_W, then by+1) and increments completed blocks.
  - row_final_in with r≠7 → err[0]. r resyncs to 0 and the block still counts.
  - r=7 without row_final_in → err[0]. r wraps to 0; the block does not advance.
  - A row received after BLOCKS_W*BLOCKS_H blocks have completed → err[1]. The write is suppressed.
  - All blocks completing during FEED is legal: feeding continues to the last byte, then DRAIN exits on its first cycle.
- Idle counter: resets on every row_valid_in and on entry to DRAIN; counts only in DRAIN.
- Arithmetic: the address is computed from registered counters, unsigned and truncated to ADDR_W. It is never negative.

Decomposition:
- jpeg_pkg: state enum (IDLE, CLEAR, FEED, DRAIN, DONE), error-bit index constants, ROW_W=64.
- One sub-module, bit_serializer: a byte valid/ready to serial bit stream with last tracking.
- Row writer and FSM stay in the top level.

Test Plan:
- Feed bytes 0xA5, 0x3C (last) with valid held high → serial_out 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on 16 consecutive valid cycles, then → DRAIN.
- BLOCKS_W=2, BLOCKS_H=1; drive 16 rows with final on rows 7 and 15 → addresses 0,2,4,…,14 then 1,3,…,15; done_out=1; err_out=0.
- row_final_in on the 5th row of a block → err_out[0]=1. The next block writes start at r=0 of bx+1.
- Row after all blocks complete → err_out[1]=1; no wr_en_out.
- TIMEOUT=16, no rows in DRAIN → DONE after 16 cycles; err_out=3'b100.
- rst_in=0 mid-FEED → next cycle state IDLE, dec_rst_out=1, serial_valid_out=0, byte_ready_out=0. start_in is ignored during FEED.
